// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, parser types and the beat byte-lane helper.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    // Beat index (8 bytes per beat) holding each header field group.
    localparam logic [2:0] W_ETH1 = 3'd1;
    localparam logic [2:0] W_IP2  = 3'd2;
    localparam logic [2:0] W_IP3  = 3'd3;
    localparam logic [2:0] W_UDP4 = 3'd4;
    localparam logic [2:0] W_KEY0 = 3'd5;
    localparam logic [2:0] W_KEY1 = 3'd6;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} rx_state_t;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [63:0] key;
    } udp_fields_t;

    // n is the absolute frame byte offset; only its lane within the beat matters.
    function automatic logic [7:0] get_byte(input logic [63:0] beat, input int unsigned n);
        return beat[8*(n%8) +: 8];
    endfunction

endpackage

// File: rtl/stat_cnt32.sv
// 32-bit wrapping statistics counter.
module stat_cnt32 (
    input  logic        clk156,
    input  logic        eth_rst,
    input  logic        inc,
    output logic [31:0] cnt
);

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst)  cnt <= '0;
        else if (inc) cnt <= cnt + 32'd1;
    end

endmodule

// File: rtl/udp_rx_parser.sv
// Parses an Ethernet/IPv4/UDP RX stream and extracts an 8-byte key from matching frames.
module udp_rx_parser
    import eth_pkg::*;
#(
    parameter logic [15:0] UDP_PORT  = 16'd10000,
    parameter int          KEY_WIDTH = 64
) (
    input  logic                 clk156,
    input  logic                 eth_rst,
    input  logic                 s_axis_tvalid,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tuser,
    output logic                 key_valid,
    output logic [KEY_WIDTH-1:0] key_data,
    output logic [31:0]          src_ip,
    output logic [31:0]          dst_ip,
    output logic [15:0]          src_port,
    output logic [15:0]          dst_port,
    output logic [31:0]          pkt_cnt,
    output logic [31:0]          match_cnt,
    output logic [31:0]          drop_cnt
);

    rx_state_t   state;
    logic [2:0]  idx;
    udp_fields_t cap_q, cap_nxt, out_q;
    logic [63:0] d;
    logic        hdr_fail, hdr_done, bad, full, end_beat, match, drop;
    logic        unused_keep;

    assign d           = s_axis_tdata;
    assign unused_keep = ^s_axis_tkeep[7:2];

    always_comb begin
        hdr_fail = 1'b0;
        cap_nxt  = cap_q;
        if (state == HDR) begin
            case (idx)
                W_ETH1: hdr_fail = ({get_byte(d, 12), get_byte(d, 13)} != ETHERTYPE_IPV4) ||
                                   (get_byte(d, 14) != IPV4_VER_IHL);
                // MF flag plus the 13-bit offset; DF is allowed.
                W_IP2:  hdr_fail = (get_byte(d, 23) != IP_PROTO_UDP) ||
                                   (({get_byte(d, 20), get_byte(d, 21)} & 16'h3FFF) != 16'h0);
                W_IP3: begin
                    cap_nxt.src_ip         = {get_byte(d, 26), get_byte(d, 27), get_byte(d, 28), get_byte(d, 29)};
                    cap_nxt.dst_ip[31:16]  = {get_byte(d, 30), get_byte(d, 31)};
                end
                W_UDP4: begin
                    cap_nxt.dst_ip[15:0]   = {get_byte(d, 32), get_byte(d, 33)};
                    cap_nxt.src_port       = {get_byte(d, 34), get_byte(d, 35)};
                    cap_nxt.dst_port       = {get_byte(d, 36), get_byte(d, 37)};
                    hdr_fail               = {get_byte(d, 36), get_byte(d, 37)} != UDP_PORT;
                end
                W_KEY0: cap_nxt.key[63:16] = {get_byte(d, 42), get_byte(d, 43), get_byte(d, 44),
                                              get_byte(d, 45), get_byte(d, 46), get_byte(d, 47)};
                W_KEY1: cap_nxt.key[15:0]  = {get_byte(d, 48), get_byte(d, 49)};
                default: ;
            endcase
        end
    end

    // A frame is complete only once key bytes 48..49 are actually present.
    assign hdr_done = (state == HDR) && (idx == W_KEY1) && (s_axis_tkeep[1:0] == 2'b11);
    assign bad      = (state == DROP) || hdr_fail;
    assign full     = (state == PAYLOAD) || hdr_done;
    assign end_beat = s_axis_tvalid && s_axis_tlast;
    assign match    = end_beat && s_axis_tuser && !bad && full;
    assign drop     = end_beat && (!s_axis_tuser || (!bad && !full));

    always_ff @(posedge clk156 or posedge eth_rst) begin
        if (eth_rst) begin
            state     <= IDLE;
            idx       <= '0;
            key_valid <= 1'b0;
            cap_q     <= '0;
            out_q     <= '0;
        end else begin
            key_valid <= match;
            if (match) out_q <= cap_nxt;
            if (s_axis_tvalid) begin
                cap_q <= cap_nxt;
                idx   <= s_axis_tlast ? 3'd0 : (idx == 3'd7) ? idx : idx + 3'd1;
                if (s_axis_tlast) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE: state <= HDR;
                        HDR: begin
                            if (hdr_fail)      state <= DROP;
                            else if (hdr_done) state <= PAYLOAD;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign key_data = out_q.key;
    assign src_ip   = out_q.src_ip;
    assign dst_ip   = out_q.dst_ip;
    assign src_port = out_q.src_port;
    assign dst_port = out_q.dst_port;

    stat_cnt32 u_pkt_cnt   (.clk156(clk156), .eth_rst(eth_rst), .inc(end_beat), .cnt(pkt_cnt));
    stat_cnt32 u_match_cnt (.clk156(clk156), .eth_rst(eth_rst), .inc(match),    .cnt(match_cnt));
    stat_cnt32 u_drop_cnt  (.clk156(clk156), .eth_rst(eth_rst), .inc(drop),     .cnt(drop_cnt));

endmodule

// File: tb/tb_udp_rx_parser.sv
// Self-checking bench for udp_rx_parser: directed frames plus randomized frames vs a byte-level model.
module tb_udp_rx_parser;

    localparam int SILENT = 0, MATCH = 1, DROPPED = 2;

    logic        clk156 = 1'b0;
    logic        eth_rst = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        key_valid;
    logic [63:0] key_data;
    logic [31:0] src_ip, dst_ip, pkt_cnt, match_cnt, drop_cnt;
    logic [15:0] src_port, dst_port;

    int          n_chk = 0, n_err = 0, n_pulse = 0, exp_pulse = 0;
    logic [31:0] m_pkt = '0, m_match = '0, m_drop = '0;
    logic [31:0] e_src = '0, e_dst = '0;
    logic [15:0] e_sp = '0, e_dp = '0;
    logic [63:0] e_key = '0;
    logic [7:0]  fb [0:127];

    udp_rx_parser #(.UDP_PORT(16'd10000), .KEY_WIDTH(64)) dut (
        .clk156(clk156), .eth_rst(eth_rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .key_valid(key_valid), .key_data(key_data), .src_ip(src_ip), .dst_ip(dst_ip),
        .src_port(src_port), .dst_port(dst_port),
        .pkt_cnt(pkt_cnt), .match_cnt(match_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk156 = ~clk156;
    always @(negedge clk156) if (key_valid) n_pulse++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_frame(input logic [31:0] sip, input logic [31:0] dip,
                               input logic [15:0] sp, input logic [15:0] dp, input logic [63:0] key);
        for (int i = 0; i < 128; i++) fb[i] = 8'($urandom);
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45;
        fb[20] = ($urandom_range(0, 1) != 0) ? 8'h40 : 8'h00;
        fb[21] = 8'h00; fb[23] = 8'h11;
        for (int i = 0; i < 4; i++) fb[26+i] = sip[31-8*i -: 8];
        for (int i = 0; i < 4; i++) fb[30+i] = dip[31-8*i -: 8];
        fb[34] = sp[15:8]; fb[35] = sp[7:0];
        fb[36] = dp[15:8]; fb[37] = dp[7:0];
        for (int i = 0; i < 8; i++) fb[42+i] = key[63-8*i -: 8];
    endtask

    // Frame outcome from the byte image: checks apply to every beat that arrived.
    function automatic int classify(input int len, input bit tuser);
        int nb;
        bit fail;
        nb = (len + 7) / 8;
        fail = 1'b0;
        if (!tuser) return DROPPED;
        if (nb > 1 && ({fb[12], fb[13]} != 16'h0800 || fb[14] != 8'h45)) fail = 1'b1;
        if (nb > 2 && (fb[23] != 8'h11 || fb[20][5] || fb[20][4:0] != 5'd0 || fb[21] != 8'd0)) fail = 1'b1;
        if (nb > 4 && {fb[36], fb[37]} != 16'd10000) fail = 1'b1;
        if (fail) return SILENT;
        return (len >= 50) ? MATCH : DROPPED;
    endfunction

    // gap_mode: 0 none, 1 idle cycle before every beat after the first, 2 random idles.
    task automatic send_frame(input int len, input bit tuser, input int gap_mode, input int abort_at);
        int nb, r;
        nb = (len + 7) / 8;
        r  = classify(len, tuser);
        for (int b = 0; b < nb; b++) begin
            if (b > 0 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0))) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b1;
                s_axis_tdata  = {$urandom, $urandom};
                @(posedge clk156); #1;
            end
            s_axis_tvalid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                s_axis_tdata[8*i +: 8] = fb[8*b+i];
                s_axis_tkeep[i]        = (8*b + i < len);
            end
            s_axis_tlast = (b == nb - 1);
            s_axis_tuser = (b == nb - 1) ? tuser : 1'($urandom);
            if (b == abort_at) begin
                #2 eth_rst = 1'b1;
                #1 s_axis_tvalid = 1'b0;
                m_pkt = '0; m_match = '0; m_drop = '0;
                e_src = '0; e_dst = '0; e_sp = '0; e_dp = '0; e_key = '0;
                chk("rst_kv", key_valid, 1'b0);
                chk("rst_key", key_data, e_key);
                chk("rst_pkt", pkt_cnt, m_pkt);
                chk("rst_match", match_cnt, m_match);
                chk("rst_drop", drop_cnt, m_drop);
                @(posedge clk156); #1;
                eth_rst = 1'b0;
                return;
            end
            @(posedge clk156); #1;
        end
        m_pkt++;
        if (r == MATCH) begin
            m_match++;
            exp_pulse++;
            e_src = {fb[26], fb[27], fb[28], fb[29]};
            e_dst = {fb[30], fb[31], fb[32], fb[33]};
            e_sp  = {fb[34], fb[35]};
            e_dp  = {fb[36], fb[37]};
            e_key = {fb[42], fb[43], fb[44], fb[45], fb[46], fb[47], fb[48], fb[49]};
        end else if (r == DROPPED) begin
            m_drop++;
        end
        chk("key_valid", key_valid, r == MATCH);
        chk("key_data", key_data, e_key);
        chk("src_ip", src_ip, e_src);
        chk("dst_ip", dst_ip, e_dst);
        chk("src_port", src_port, e_sp);
        chk("dst_port", dst_port, e_dp);
        chk("pkt_cnt", pkt_cnt, m_pkt);
        chk("match_cnt", match_cnt, m_match);
        chk("drop_cnt", drop_cnt, m_drop);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk156);
        #1;
        chk("reset_kv", key_valid, 1'b0);
        chk("reset_key", key_data, 64'd0);
        chk("reset_sip", src_ip, 32'd0);
        chk("reset_dip", dst_ip, 32'd0);
        chk("reset_ports", {src_port, dst_port}, 32'd0);
        chk("reset_cnts", {pkt_cnt, match_cnt}, 64'd0);
        chk("reset_drop", drop_cnt, 32'd0);
        eth_rst = 1'b0;
        @(posedge clk156); #1;

        // Reference matching frame, then the same frame with a bad FCS.
        build_frame(32'h0A000001, 32'h0A000002, 16'd4000, 16'd10000, 64'h0102030405060708);
        send_frame(64, 1'b1, 0, -1);
        chk("ref_key", key_data, 64'h0102030405060708);
        chk("ref_sip", src_ip, 32'h0A000001);
        chk("ref_sport", src_port, 16'd4000);
        chk("ref_match", match_cnt, 32'd1);
        send_frame(64, 1'b0, 0, -1);
        chk("fcs_drop", drop_cnt, 32'd1);
        chk("fcs_pkt", pkt_cnt, 32'd2);

        // Negative frames: IPv6 EtherType, wrong port, MF fragment.
        build_frame(32'h0A000001, 32'h0A000002, 16'd4000, 16'd10000, 64'h1111);
        fb[12] = 8'h86; fb[13] = 8'hDD;
        send_frame(64, 1'b1, 0, -1);
        build_frame(32'h0A000001, 32'h0A000002, 16'd4000, 16'd9999, 64'h2222);
        send_frame(64, 1'b1, 0, -1);
        build_frame(32'h0A000001, 32'h0A000002, 16'd4000, 16'd10000, 64'h3333);
        fb[20] = 8'h20;
        send_frame(64, 1'b1, 0, -1);
        chk("neg_drop", drop_cnt, 32'd1);
        chk("neg_pkt", pkt_cnt, 32'd5);

        // Back-to-back pair, then a frame gapped every other beat.
        build_frame(32'hC0A80101, 32'hC0A80102, 16'd1234, 16'd10000, 64'hA1A2A3A4A5A6A7A8);
        send_frame(64, 1'b1, 0, -1);
        build_frame(32'hC0A80103, 32'hC0A80104, 16'd5678, 16'd10000, 64'hB1B2B3B4B5B6B7B8);
        send_frame(72, 1'b1, 0, -1);
        build_frame(32'hC0A80105, 32'hC0A80106, 16'd9, 16'd10000, 64'hC1C2C3C4C5C6C7C8);
        send_frame(64, 1'b1, 1, -1);
        chk("b2b_match", match_cnt, 32'd4);

        // 5-beat runt, then reset at word 3 of a matching frame, then recovery.
        build_frame(32'h01020304, 32'h05060708, 16'd1, 16'd10000, 64'h55);
        send_frame(40, 1'b1, 0, -1);
        chk("runt_drop", drop_cnt, 32'd2);
        build_frame(32'h01020304, 32'h05060708, 16'd1, 16'd10000, 64'h66);
        send_frame(64, 1'b1, 0, 3);
        repeat (2) @(posedge clk156);
        #1;
        chk("post_rst_kv", key_valid, 1'b0);
        build_frame(32'h0A0B0C0D, 32'h0E0F1011, 16'd77, 16'd10000, 64'hDEADBEEFCAFEF00D);
        send_frame(50, 1'b1, 0, -1);
        chk("recover_key", key_data, 64'hDEADBEEFCAFEF00D);
        build_frame(32'h0A0B0C0D, 32'h0E0F1011, 16'd77, 16'd10000, 64'h77);
        send_frame(49, 1'b1, 0, -1);

        // Drop counter wrap.
        force dut.u_drop_cnt.cnt = 32'hFFFF_FFFF;
        @(posedge clk156); #1;
        release dut.u_drop_cnt.cnt;
        m_drop = 32'hFFFF_FFFF;
        chk("drop_preload", drop_cnt, 32'hFFFF_FFFF);
        build_frame(32'h1, 32'h2, 16'd3, 16'd10000, 64'h4);
        send_frame(40, 1'b1, 0, -1);
        chk("drop_wrap", drop_cnt, 32'd0);

        // Randomized frames.
        for (int n = 0; n < 60; n++) begin
            int len, kind;
            build_frame($urandom, $urandom, 16'($urandom), 16'd10000, {$urandom, $urandom});
            kind = $urandom_range(0, 9);
            case (kind)
                5: fb[14] = 8'h46;
                6: fb[23] = 8'h06;
                7: fb[21] = 8'h01;
                8: fb[37] = fb[37] ^ 8'h01;
                9: fb[12] = 8'h86;
                default: ;
            endcase
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 49) : $urandom_range(50, 128);
            send_frame(len, $urandom_range(0, 7) != 0, $urandom_range(0, 2), -1);
            if ($urandom_range(0, 1) != 0) begin
                s_axis_tlast = 1'b1;
                @(posedge clk156); #1;
                s_axis_tlast = 1'b0;
            end
        end

        repeat (3) @(posedge clk156);
        #1;
        chk("pulse_total", n_pulse, exp_pulse);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
